// File: rtl/jk_pkg.sv
// ============================================================================
// Module      : jk_pkg
// Description : Shared JK action encoding and default counter geometry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jk_pkg;

  localparam int c_DEFAULT_WIDTH   = 4;
  localparam int c_DEFAULT_MODULUS = 10;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_action_e;

  function automatic jk_action_e jk_action(input logic j, input logic k);
    jk_action_e act;
    case ({j, k})
      2'b01:   act = JK_RESET;
      2'b10:   act = JK_SET;
      2'b11:   act = JK_TOGGLE;
      default: act = JK_HOLD;
    endcase
    return act;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jk_ff_bit.sv
// ============================================================================
// Module      : jk_ff_bit
// Description : One edge-triggered JK flip-flop with asynchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_ff_bit (
  input  logic clk,
  input  logic CLR_N,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic QBAR
);

  import jk_pkg::*;

  logic r_q;

  always_ff @(posedge clk or negedge CLR_N) begin
    if (!CLR_N) begin
      r_q <= 1'b0;
    end else begin
      case (jk_action(J, K))
        JK_RESET:  r_q <= 1'b0;
        JK_SET:    r_q <= 1'b1;
        JK_TOGGLE: r_q <= ~r_q;
        default:   r_q <= r_q;
      endcase
    end
  end

  assign Q    = r_q;
  assign QBAR = ~r_q;

endmodule

`default_nettype wire

// File: rtl/jk_sync_counter.sv
// ============================================================================
// Module      : jk_sync_counter
// Description : Cascadable modulo-N up/down counter built from JK bits.
//               Macro JK_SYNC_COUNTER_TC_REG_EN selects a registered TC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_sync_counter #(
  parameter int WIDTH   = jk_pkg::c_DEFAULT_WIDTH,
  parameter int MODULUS = jk_pkg::c_DEFAULT_MODULUS
) (
  input  logic             clk,
  input  logic             CLR_N,
  input  logic             CI,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QBAR,
  output logic             TC,
  output logic             ERR
);

  import jk_pkg::*;

  localparam logic [WIDTH:0]   c_MODULUS = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] c_MAX     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] c_ZERO    = '0;

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qbar;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_t_up;
  logic [WIDTH-1:0] w_t_dn;
  logic [WIDTH-1:0] w_load_val;
  logic             w_load_ok;
  logic             w_at_max;
  logic             w_at_zero;
  logic             r_err;

  assign w_load_ok  = ({1'b0, D} < c_MODULUS);
  assign w_load_val = w_load_ok ? D : c_ZERO;
  assign w_at_max   = (w_q == c_MAX);
  assign w_at_zero  = (w_q == c_ZERO);

  // Binary step toggle terms: AND of all lower bits (up) or lower complements (down).
  always_comb begin
    logic v_up;
    logic v_dn;
    v_up   = 1'b1;
    v_dn   = 1'b1;
    w_t_up = '0;
    w_t_dn = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_t_up[i] = v_up;
      w_t_dn[i] = v_dn;
      v_up      = v_up & w_q[i];
      v_dn      = v_dn & w_qbar[i];
    end
  end

  always_comb begin
    w_j = '0;
    w_k = '0;
    if (LOAD) begin
      w_j = w_load_val;
      w_k = ~w_load_val;
    end else if (CI) begin
      if (UP) begin
        if (w_at_max) begin
          w_j = c_ZERO;
          w_k = ~c_ZERO;
        end else begin
          w_j = w_t_up;
          w_k = w_t_up;
        end
      end else begin
        if (w_at_zero) begin
          w_j = c_MAX;
          w_k = ~c_MAX;
        end else begin
          w_j = w_t_dn;
          w_k = w_t_dn;
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_ff_bit u_bit (
        .clk  (clk),
        .CLR_N(CLR_N),
        .J    (w_j[i]),
        .K    (w_k[i]),
        .Q    (w_q[i]),
        .QBAR (w_qbar[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge CLR_N) begin
    if (!CLR_N) begin
      r_err <= 1'b0;
    end else if (LOAD && !w_load_ok) begin
      r_err <= 1'b1;
    end
  end

`ifdef JK_SYNC_COUNTER_TC_REG_EN
  logic [WIDTH-1:0] w_q_next;
  logic             w_tc_next;
  logic             r_tc;

  assign w_q_next  = (w_j & w_qbar) | (~w_k & w_q);
  assign w_tc_next = CI & ((UP & (w_q_next == c_MAX)) | (~UP & (w_q_next == c_ZERO)));

  always_ff @(posedge clk or negedge CLR_N) begin
    if (!CLR_N) begin
      r_tc <= 1'b0;
    end else begin
      r_tc <= w_tc_next;
    end
  end

  assign TC = r_tc;
`else
  // Gated by CLR_N so a held reset with UP=0 cannot decode Q==0 as terminal.
  assign TC = CLR_N & CI & ((UP & w_at_max) | (~UP & w_at_zero));
`endif

  assign Q    = w_q;
  assign QBAR = w_qbar;
  assign ERR  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_jk_sync_counter.sv
// ============================================================================
// Module      : tb_jk_sync_counter
// Description : Directed plus random checks of jk_sync_counter (mod 10, mod 16, cascade).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jk_sync_counter;

`ifdef JK_SYNC_COUNTER_TC_REG_EN
  localparam bit c_TC_REG = 1'b1;
`else
  localparam bit c_TC_REG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr_n, ci, up, load;
  logic [3:0] d;
  logic [3:0] q10, qb10, q16, qb16;
  logic       tc10, err10, tc16, err16;

  logic       cas_clr_n, cas_ci;
  logic [3:0] uq, uqb, tq, tqb;
  logic       utc, uerr, ttc, terr;

  always #5 clk = ~clk;

  jk_sync_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (
    .clk(clk), .CLR_N(clr_n), .CI(ci), .UP(up), .LOAD(load), .D(d),
    .Q(q10), .QBAR(qb10), .TC(tc10), .ERR(err10));

  jk_sync_counter #(.WIDTH(4), .MODULUS(16)) u_dut16 (
    .clk(clk), .CLR_N(clr_n), .CI(ci), .UP(up), .LOAD(load), .D(d),
    .Q(q16), .QBAR(qb16), .TC(tc16), .ERR(err16));

  jk_sync_counter #(.WIDTH(4), .MODULUS(10)) u_units (
    .clk(clk), .CLR_N(cas_clr_n), .CI(cas_ci), .UP(1'b1), .LOAD(1'b0), .D(4'd0),
    .Q(uq), .QBAR(uqb), .TC(utc), .ERR(uerr));

  jk_sync_counter #(.WIDTH(4), .MODULUS(10)) u_tens (
    .clk(clk), .CLR_N(cas_clr_n), .CI(utc), .UP(1'b1), .LOAD(1'b0), .D(4'd0),
    .Q(tq), .QBAR(tqb), .TC(ttc), .ERR(terr));

  int vectors     = 0;
  int miscompares = 0;
  int mods[2];
  int mq[2];
  bit merr[2];
  bit mtcr[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int next_q(int q, int m, bit c, bit u, bit l, int dv);
    if (l) return (dv < m) ? dv : 0;
    if (c) return u ? (q + 1) % m : (q + m - 1) % m;
    return q;
  endfunction

  function automatic bit tc_dec(int q, int m, bit c, bit u);
    return c && ((u && q == m - 1) || (!u && q == 0));
  endfunction

  function automatic bit exp_tc(int k);
    if (!clr_n) return 1'b0;
    return c_TC_REG ? mtcr[k] : tc_dec(mq[k], mods[k], ci, up);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k] = 0; merr[k] = 1'b0; mtcr[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int nq;
    if (!clr_n) return;
    for (int k = 0; k < 2; k++) begin
      nq = next_q(mq[k], mods[k], ci, up, load, int'(d));
      if (load && int'(d) >= mods[k]) merr[k] = 1'b1;
      mtcr[k] = tc_dec(nq, mods[k], ci, up);
      mq[k]   = nq;
    end
  endtask

  task automatic check_tc(input string tag);
    chk({tag, ".tc10"}, tc10, exp_tc(0));
    chk({tag, ".tc16"}, tc16, exp_tc(1));
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q10"},   q10,   mq[0]);
    chk({tag, ".qb10"},  qb10,  (~mq[0]) & 15);
    chk({tag, ".err10"}, err10, merr[0]);
    chk({tag, ".q16"},   q16,   mq[1]);
    chk({tag, ".qb16"},  qb16,  (~mq[1]) & 15);
    chk({tag, ".err16"}, err16, merr[1]);
    check_tc(tag);
  endtask

  // Called just after a falling edge: drive, check pre-edge TC, clock, check state.
  task automatic step(input bit c, input bit u, input bit l, input logic [3:0] dv, input string tag);
    ci = c; up = u; load = l; d = dv;
    #1;
    check_tc({tag, ".pre"});
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    mods[0] = 10; mods[1] = 16;
    clr_n = 1'b0; ci = 1'b1; up = 1'b1; load = 1'b0; d = 4'd0;
    cas_clr_n = 1'b0; cas_ci = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    clr_n = 1'b1;

    for (int n = 0; n < 12; n++) step(1'b1, 1'b1, 1'b0, 4'd0, "up");
    chk("up12.q10", q10, 2);

    step(1'b0, 1'b1, 1'b1, 4'd0, "ld0");
    for (int n = 0; n < 3; n++) step(1'b1, 1'b0, 1'b0, 4'd0, "down");
    chk("down3.q10", q10, 7);

    step(1'b1, 1'b1, 1'b1, 4'd7, "ld7");
    step(1'b1, 1'b1, 1'b0, 4'd0, "ld7inc");

    step(1'b0, 1'b1, 1'b1, 4'd12, "ld12");
    chk("ld12.err10", err10, 1);
    step(1'b0, 1'b1, 1'b1, 4'd3, "ld3");
    clr_n = 1'b0;
    model_reset();
    #1;
    check_all("clrpulse");
    @(negedge clk);
    clr_n = 1'b1;
    check_all("clrrel");

    step(1'b0, 1'b1, 1'b1, 4'd4, "ld4");
    for (int n = 0; n < 5; n++) step(1'b0, 1'b1, 1'b0, 4'd0, "hold");

    step(1'b1, 1'b1, 1'b0, 4'd0, "run");
    @(posedge clk);
    model_edge();
    #2;
    clr_n = 1'b0;
    model_reset();
    #1;
    check_all("async_clr");
    @(negedge clk);
    clr_n = 1'b1;

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        clr_n = 1'b0;
        model_reset();
        #1;
        check_all("rnd_clr");
        @(negedge clk);
        clr_n = 1'b1;
      end
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)), "rnd");
    end

    cas_clr_n = 1'b1;
    cas_ci    = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk);
      @(negedge clk);
      chk("cas.units", uq, n % 10);
      chk("cas.tens",  tq, n / 10);
      chk("cas.utc",   utc, (n % 10 == 9) ? 1 : 0);
    end
    chk("cas.uqb",  uqb, 4'hA);
    chk("cas.tqb",  tqb, 4'hD);
    chk("cas.ttc",  ttc, 0);
    chk("cas.err",  {uerr, terr}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
